// File: rtl/sram_arbiter_2x1.sv
// Two-master arbiter in front of a single-port synchronous SRAM.
// Same-cycle grant, burst-limited round-robin, 1-cycle read data routed back to its issuer.
module sram_arbiter_2x1 #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            m0_en,
    input  logic [3:0]      m0_wen,
    input  logic [XLEN-1:0] m0_addr,
    input  logic [XLEN-1:0] m0_wdata,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [XLEN-1:0] m0_rdata,

    input  logic            m1_en,
    input  logic [3:0]      m1_wen,
    input  logic [XLEN-1:0] m1_addr,
    input  logic [XLEN-1:0] m1_wdata,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [XLEN-1:0] m1_rdata,

    output logic            sram_en,
    output logic [3:0]      sram_wen,
    output logic [XLEN-1:0] sram_addr,
    output logic [XLEN-1:0] sram_wdata,
    input  logic [XLEN-1:0] sram_rdata
);

    localparam int unsigned    CntW   = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST);

    logic            cur_q, cur_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rd_v_q, rd_v_d;
    logic            rd_own_q, rd_own_d;

    logic any_req;
    logic win;

    // Gating with reset keeps every output at 0 while reset is held.
    always_comb begin
        any_req = reset & (m0_en | m1_en);
        if (m0_en && m1_en) begin
            win = (cnt_q < CntMax) ? cur_q : ~cur_q;
        end else begin
            win = m1_en;
        end
    end

    assign m0_gnt = any_req & ~win;
    assign m1_gnt = any_req & win;

    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = 4'b0000;
        sram_addr  = '0;
        sram_wdata = '0;
        if (any_req) begin
            sram_en    = 1'b1;
            sram_wen   = win ? m1_wen   : m0_wen;
            sram_addr  = win ? m1_addr  : m0_addr;
            sram_wdata = win ? m1_wdata : m0_wdata;
        end
    end

    always_comb begin
        cur_d    = cur_q;
        cnt_d    = cnt_q;
        rd_v_d   = 1'b0;
        rd_own_d = rd_own_q;
        if (!any_req) begin
            cnt_d = '0;
        end else if (win == cur_q) begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
        end else begin
            cur_d = win;
            cnt_d = CntW'(1);
        end
        if (any_req && (sram_wen == 4'b0000)) begin
            rd_v_d   = 1'b1;
            rd_own_d = win;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_q    <= 1'b0;
            cnt_q    <= '0;
            rd_v_q   <= 1'b0;
            rd_own_q <= 1'b0;
        end else begin
            cur_q    <= cur_d;
            cnt_q    <= cnt_d;
            rd_v_q   <= rd_v_d;
            rd_own_q <= rd_own_d;
        end
    end

    assign m0_rvalid = rd_v_q & ~rd_own_q;
    assign m1_rvalid = rd_v_q & rd_own_q;
    assign m0_rdata  = m0_rvalid ? sram_rdata : '0;
    assign m1_rdata  = m1_rvalid ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_arbiter_2x1.sv
// Directed bench for sram_arbiter_2x1 with a small behavioural SRAM behind it.
module tb_sram_arbiter_2x1;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_en, m1_en;
    logic [3:0]  m0_wen, m1_wen;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    sram_arbiter_2x1 #(.XLEN(32), .MAX_BURST(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_en      (m0_en),
        .m0_wen     (m0_wen),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_gnt     (m0_gnt),
        .m0_rvalid  (m0_rvalid),
        .m0_rdata   (m0_rdata),
        .m1_en      (m1_en),
        .m1_wen     (m1_wen),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_gnt     (m1_gnt),
        .m1_rvalid  (m1_rvalid),
        .m1_rdata   (m1_rdata),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // Word-addressed SRAM model with byte enables and 1-cycle read latency.
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_wen == 4'b0000) begin
                sram_rdata <= mem[sram_addr[9:2]];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_wen[b]) mem[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_en = 1'b0; m0_wen = 4'h0; m0_addr = '0; m0_wdata = '0;
        m1_en = 1'b0; m1_wen = 4'h0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int exp_w;
        int prev_w;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
        sram_rdata = '0;
        do_reset();

        // Reset state
        #2;
        check("rst_gnt0", {31'b0, m0_gnt}, 32'd0);
        check("rst_sram_en", {31'b0, sram_en}, 32'd0);
        check("rst_rvalid1", {31'b0, m1_rvalid}, 32'd0);

        // Single m0 read of 0x10
        tick();
        m0_en = 1'b1; m0_addr = 32'h10;
        #2;
        check("t1_gnt0", {31'b0, m0_gnt}, 32'd1);
        check("t1_gnt1", {31'b0, m1_gnt}, 32'd0);
        check("t1_sram_en", {31'b0, sram_en}, 32'd1);
        check("t1_sram_addr", sram_addr, 32'h10);
        tick();
        m0_en = 1'b0;
        #2;
        check("t1_rvalid0", {31'b0, m0_rvalid}, 32'd1);
        check("t1_rdata0", m0_rdata, 32'hA500_0004);
        check("t1_rvalid1", {31'b0, m1_rvalid}, 32'd0);
        check("t1_idle_en", {31'b0, sram_en}, 32'd0);

        // Both masters read continuously: m0 x4, m1 x4, m0 x4
        do_reset();
        m0_en = 1'b1; m0_addr = 32'h0;
        m1_en = 1'b1; m1_addr = 32'h40;
        prev_w = -1;
        for (int c = 0; c < 13; c++) begin
            #2;
            exp_w = (c / 4) % 2;
            if (c < 12) begin
                check($sformatf("t2_gnt0_c%0d", c), {31'b0, m0_gnt}, (exp_w == 0) ? 32'd1 : 32'd0);
                check($sformatf("t2_gnt1_c%0d", c), {31'b0, m1_gnt}, (exp_w == 1) ? 32'd1 : 32'd0);
            end
            if (prev_w >= 0) begin
                check($sformatf("t2_rv0_c%0d", c), {31'b0, m0_rvalid},
                      (prev_w == 0) ? 32'd1 : 32'd0);
                check($sformatf("t2_rv1_c%0d", c), {31'b0, m1_rvalid},
                      (prev_w == 1) ? 32'd1 : 32'd0);
                if (prev_w == 0) check($sformatf("t2_rd0_c%0d", c), m0_rdata, 32'hA500_0000);
                else             check($sformatf("t2_rd1_c%0d", c), m1_rdata, 32'hA500_0010);
            end
            prev_w = exp_w;
            tick();
            if (c == 11) begin
                m0_en = 1'b0; m1_en = 1'b0;
            end
        end

        // m1 streams alone 10 cycles, then m0 joins
        do_reset();
        m1_en = 1'b1; m1_addr = 32'h40;
        for (int c = 0; c < 10; c++) begin
            #2;
            check($sformatf("t3_solo1_c%0d", c), {31'b0, m1_gnt}, 32'd1);
            tick();
        end
        m0_en = 1'b1; m0_addr = 32'h8;
        for (int c = 0; c < 5; c++) begin
            #2;
            check($sformatf("t3_gnt0_c%0d", c), {31'b0, m0_gnt}, (c < 4) ? 32'd1 : 32'd0);
            check($sformatf("t3_gnt1_c%0d", c), {31'b0, m1_gnt}, (c < 4) ? 32'd0 : 32'd1);
            tick();
        end

        // m0 write collides with m1 read of the same word
        do_reset();
        m0_en = 1'b1; m0_wen = 4'hF; m0_addr = 32'h20; m0_wdata = 32'hDEAD_BEEF;
        m1_en = 1'b1; m1_addr = 32'h20;
        #2;
        check("t4_gnt0", {31'b0, m0_gnt}, 32'd1);
        check("t4_gnt1", {31'b0, m1_gnt}, 32'd0);
        check("t4_sram_wen", {28'b0, sram_wen}, 32'hF);
        check("t4_sram_addr", sram_addr, 32'h20);
        check("t4_sram_wdata", sram_wdata, 32'hDEAD_BEEF);
        tick();
        m0_en = 1'b0; m0_wen = 4'h0;
        #2;
        check("t4_gnt1_next", {31'b0, m1_gnt}, 32'd1);
        check("t4_no_rv0", {31'b0, m0_rvalid}, 32'd0);
        check("t4_no_rv1", {31'b0, m1_rvalid}, 32'd0);
        tick();
        m1_en = 1'b0;
        #2;
        check("t4_rv1", {31'b0, m1_rvalid}, 32'd1);
        check("t4_rd1", m1_rdata, 32'hDEAD_BEEF);

        // Reset pulse while an m1 read is returning
        do_reset();
        m1_en = 1'b1; m1_addr = 32'h44;
        tick();
        m1_en = 1'b0;
        #1;
        check("t5_rv1_pre", {31'b0, m1_rvalid}, 32'd1);
        m0_en = 1'b1; m1_en = 1'b1;
        reset = 1'b0;
        #1;
        check("t5_rv1_rst", {31'b0, m1_rvalid}, 32'd0);
        check("t5_rd1_rst", m1_rdata, 32'd0);
        check("t5_en_rst", {31'b0, sram_en}, 32'd0);
        check("t5_addr_rst", sram_addr, 32'd0);
        check("t5_gnt_rst", {30'b0, m1_gnt, m0_gnt}, 32'd0);
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        #2;
        check("t5_no_stale", {31'b0, m1_rvalid}, 32'd0);
        m0_en = 1'b1; m1_en = 1'b1;
        #1;
        check("t5_first_m0", {31'b0, m0_gnt}, 32'd1);
        tick();
        idle_inputs();
        tick();

        // Idle cycle clears the burst count while cur stays m1
        do_reset();
        m1_en = 1'b1; m1_addr = 32'h40;
        tick();
        tick();
        m1_en = 1'b0;
        tick();
        m0_en = 1'b1; m1_en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #2;
            check($sformatf("t6_gnt1_c%0d", c), {31'b0, m1_gnt}, (c < 4) ? 32'd1 : 32'd0);
            check($sformatf("t6_gnt0_c%0d", c), {31'b0, m0_gnt}, (c < 4) ? 32'd0 : 32'd1);
            tick();
        end
        idle_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
